// File: rtl/y86_regfile_sb.sv
// y86_regfile_sb: Y86-64 decode register file with a per-register pending-claim scoreboard.
// Latency: operands registered and rd_data_valid pulsed one cycle after acceptance; writes are readable next cycle.
// Backpressure: rd_ready drops while a source is pending or a claim would overflow a counter.
// Optional: define REGFILE_BYPASS_EN so a same-cycle retiring writeback satisfies and feeds a read.
module y86_regfile_sb #(
  parameter int DATA_W = 64,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_valid,
  input  logic [NRD*4-1:0]      rd_addr,
  output logic                  rd_ready,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic [3:0]            claim_e,
  input  logic [3:0]            claim_m,
  input  logic                  wb_e_en,
  input  logic                  wb_m_en,
  input  logic [3:0]            wb_e_dst,
  input  logic [3:0]            wb_m_dst,
  input  logic [DATA_W-1:0]     wb_e_data,
  input  logic [DATA_W-1:0]     wb_m_data,
  output logic [14:0]           pend,
  output logic                  err
);
  localparam int NREG = 15;
  // Extra headroom bits so count + two claims or count - two writebacks never wraps.
  localparam int EW = CNT_W + 2;
  localparam logic [3:0]    RNONE   = 4'hF;
  localparam logic [EW-1:0] CNT_MAX = EW'((1 << CNT_W) - 1);

  logic [DATA_W-1:0]     regs_q [NREG];
  logic [CNT_W-1:0]      cnt_q  [NREG];
  logic [CNT_W-1:0]      cnt_d  [NREG];
  logic [EW-1:0]         dec    [NREG];
  logic [EW-1:0]         clm    [NREG];
  logic [EW-1:0]         eff    [NREG];
  logic [DATA_W-1:0]     opnd_d [NRD];
  logic [NRD*DATA_W-1:0] rd_data_q;
  logic                  rd_data_valid_q;
  logic                  err_q, err_d;
  logic                  ready, accept;

  // Per-register writeback decrements, claim increments and the count the hazard check sees.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec[r] = EW'(wb_e_en && (wb_e_dst == 4'(r))) + EW'(wb_m_en && (wb_m_dst == 4'(r)));
      clm[r] = EW'(claim_e == 4'(r)) + EW'(claim_m == 4'(r));
`ifdef REGFILE_BYPASS_EN
      eff[r] = (EW'(cnt_q[r]) >= dec[r]) ? EW'(cnt_q[r]) - dec[r] : '0;
`else
      eff[r] = EW'(cnt_q[r]);
`endif
    end
  end

  // Accept only when no source is pending and no counter would exceed its maximum; independent of rd_valid.
  always_comb begin
    ready = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      if (eff[r] + clm[r] > CNT_MAX) ready = 1'b0;
      for (int i = 0; i < NRD; i++)
        if ((rd_addr[4*i +: 4] == 4'(r)) && (eff[r] != '0)) ready = 1'b0;
    end
  end

  assign rd_ready = ready;
  assign accept   = rd_valid && ready;

  // Counter next state: clamp underflow at zero and flag it, then add accepted claims.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      if (EW'(cnt_q[r]) < dec[r]) begin
        err_d    = 1'b1;
        cnt_d[r] = CNT_W'(accept ? clm[r] : '0);
      end else begin
        cnt_d[r] = CNT_W'(EW'(cnt_q[r]) - dec[r] + (accept ? clm[r] : '0));
      end
    end
  end

  // Operand select per read port: RNONE gives 0, bypass (M over E) overrides the array.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      opnd_d[i] = '0;
      for (int r = 0; r < NREG; r++)
        if (rd_addr[4*i +: 4] == 4'(r)) opnd_d[i] = regs_q[r];
`ifdef REGFILE_BYPASS_EN
      if (rd_addr[4*i +: 4] != RNONE) begin
        if (wb_m_en && (wb_m_dst == rd_addr[4*i +: 4]))      opnd_d[i] = wb_m_data;
        else if (wb_e_en && (wb_e_dst == rd_addr[4*i +: 4])) opnd_d[i] = wb_e_data;
      end
`endif
    end
  end

  // Register array writes; M wins when both ports target the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wb_m_en && (wb_m_dst == 4'(r)))      regs_q[r] <= wb_m_data;
        else if (wb_e_en && (wb_e_dst == 4'(r))) regs_q[r] <= wb_e_data;
      end
    end
  end

  // Scoreboard counters, sticky error and registered operand outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      rd_data_valid_q <= accept;
      err_q           <= err_d;
      if (accept)
        for (int i = 0; i < NRD; i++) rd_data_q[DATA_W*i +: DATA_W] <= opnd_d[i];
    end
  end

  // Pending flags mirror nonzero counters.
  always_comb begin
    for (int r = 0; r < NREG; r++) pend[r] = (cnt_q[r] != '0);
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_y86_regfile_sb.sv
// tb_y86_regfile_sb: randomized and directed checks of y86_regfile_sb against a behavioural model.
// Latency: model updates on each rising edge; outputs compared on the falling edge.
// Backpressure: rd_ready compared every driven cycle against the model's acceptance rule.
module tb_y86_regfile_sb;
  localparam int DW  = 64;
  localparam int NRD = 4;
  localparam int MAXC = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk, rst_n, rd_valid;
  logic [NRD*4-1:0]  rd_addr;
  logic              rd_ready;
  logic [NRD*DW-1:0] rd_data;
  logic              rd_data_valid;
  logic [3:0]        claim_e, claim_m, wb_e_dst, wb_m_dst;
  logic              wb_e_en, wb_m_en;
  logic [DW-1:0]     wb_e_data, wb_m_data;
  logic [14:0]       pend;
  logic              err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                m_cnt  [15];
  logic [DW-1:0]     m_regs [15];
  bit                m_err;
  bit                m_rdv;
  logic [NRD*DW-1:0] m_rdd;

  y86_regfile_sb #(.DATA_W(DW), .NRD(NRD), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .claim_e(claim_e), .claim_m(claim_m),
    .wb_e_en(wb_e_en), .wb_m_en(wb_m_en), .wb_e_dst(wb_e_dst), .wb_m_dst(wb_m_dst),
    .wb_e_data(wb_e_data), .wb_m_data(wb_m_data), .pend(pend), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void m_reset();
    for (int r = 0; r < 15; r++) begin
      m_cnt[r] = 0;
      m_regs[r] = '0;
    end
    m_err = 0; m_rdv = 0; m_rdd = '0;
  endfunction

  function automatic int m_dec(int r);
    return int'(wb_e_en && wb_e_dst == 4'(r)) + int'(wb_m_en && wb_m_dst == 4'(r));
  endfunction

  function automatic int m_claims(int r);
    return int'(claim_e == 4'(r)) + int'(claim_m == 4'(r));
  endfunction

  function automatic int m_eff(int r);
    int c;
    c = BYP ? m_cnt[r] - m_dec(r) : m_cnt[r];
    return (c < 0) ? 0 : c;
  endfunction

  function automatic bit exp_ready();
    for (int i = 0; i < NRD; i++) begin
      int a;
      a = int'(rd_addr[4*i +: 4]);
      if (a != 15 && m_eff(a) != 0) return 1'b0;
    end
    for (int r = 0; r < 15; r++)
      if (m_eff(r) + m_claims(r) > MAXC) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [14:0] exp_pend();
    logic [14:0] p;
    for (int r = 0; r < 15; r++) p[r] = (m_cnt[r] != 0);
    return p;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_update();
    bit acc;
    logic [NRD*DW-1:0] cap;
    acc = rd_valid && exp_ready();
    cap = '0;
    for (int i = 0; i < NRD; i++) begin
      int a;
      logic [DW-1:0] v;
      a = int'(rd_addr[4*i +: 4]);
      v = '0;
      if (a != 15) begin
        v = m_regs[a];
        if (BYP && wb_m_en && int'(wb_m_dst) == a) v = wb_m_data;
        else if (BYP && wb_e_en && int'(wb_e_dst) == a) v = wb_e_data;
      end
      cap[DW*i +: DW] = v;
    end
    for (int r = 0; r < 15; r++) begin
      int c;
      c = m_cnt[r] - m_dec(r);
      if (c < 0) begin m_err = 1; c = 0; end
      if (acc) c += m_claims(r);
      m_cnt[r] = c;
    end
    if (wb_e_en && wb_e_dst != 4'hF) m_regs[wb_e_dst] = wb_e_data;
    if (wb_m_en && wb_m_dst != 4'hF) m_regs[wb_m_dst] = wb_m_data;
    m_rdv = acc;
    if (acc) m_rdd = cap;
  endfunction

  task automatic drive(input bit v, input logic [15:0] a, input logic [3:0] ce, input logic [3:0] cm);
    rd_valid = v; rd_addr = a; claim_e = ce; claim_m = cm;
  endtask

  task automatic wb(input bit ee, input logic [3:0] ed, input logic [DW-1:0] edat,
                    input bit me, input logic [3:0] md, input logic [DW-1:0] mdat);
    wb_e_en = ee; wb_e_dst = ed; wb_e_data = edat;
    wb_m_en = me; wb_m_dst = md; wb_m_data = mdat;
  endtask

  task automatic idle();
    drive(1'b0, 16'hFFFF, 4'hF, 4'hF);
    wb(1'b0, 4'hF, '0, 1'b0, 4'hF, '0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv got %b want 0", rd_data_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    checks++; if (pend !== 15'h0) begin errors++; $display("FAIL reset_pend got %h want 0", pend); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    drive(1'b1, 16'hFFF1, 4'hF, 4'hF);
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", rd_ready); end
    step();
    idle();
    checks++; if (rd_data_valid !== 1'b1) begin errors++; $display("FAIL basic_rdv got %b want 1", rd_data_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL basic_data got %h want 0", rd_data); end
    step();
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL basic_rdv_pulse got %b want 0", rd_data_valid); end
  endtask

  task automatic test_hazard();
    int k;
    bit acc;
    drive(1'b1, 16'hFFFF, 4'h2, 4'hF);
    step();
    drive(1'b1, 16'hFFF2, 4'hF, 4'hF);
    #1;
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall got %b want 0", rd_ready); end
    checks++; if (pend[2] !== 1'b1) begin errors++; $display("FAIL hazard_pend2 got %b want 1", pend[2]); end
    step();
    k = 0; acc = 0;
    while (!acc && k < 4) begin
      if (k == 0) wb(1'b1, 4'h2, 64'hAAAA, 1'b0, 4'hF, '0);
      else        wb(1'b0, 4'hF, '0, 1'b0, 4'hF, '0);
      #1;
      acc = rd_ready;
      step();
      if (!acc) k++;
    end
    idle();
    checks++; if (k !== (BYP ? 0 : 1)) begin errors++; $display("FAIL hazard_accept_cycle got %0d want %0d", k, BYP ? 0 : 1); end
    checks++; if (rd_data[63:0] !== 64'hAAAA) begin errors++; $display("FAIL hazard_data got %h want aaaa", rd_data[63:0]); end
    checks++; if (pend[2] !== 1'b0) begin errors++; $display("FAIL hazard_retired got %b want 0", pend[2]); end
  endtask

  task automatic test_popq();
    drive(1'b1, 16'hFFFF, 4'h4, 4'h4);
    step();
    idle();
    checks++; if (pend[4] !== 1'b1) begin errors++; $display("FAIL popq_pend got %b want 1", pend[4]); end
    wb(1'b1, 4'h4, 64'h11, 1'b1, 4'h4, 64'h22);
    step();
    idle();
    checks++; if (pend[4] !== 1'b0) begin errors++; $display("FAIL popq_retire got %b want 0", pend[4]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL popq_err got %b want 0", err); end
    drive(1'b1, 16'hFFF4, 4'hF, 4'hF);
    step();
    idle();
    checks++; if (rd_data[63:0] !== 64'h22) begin errors++; $display("FAIL popq_data got %h want 22", rd_data[63:0]); end
  endtask

  task automatic test_saturate();
    int k;
    bit acc;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 16'hFFFF, 4'h3, 4'hF);
      #1;
      checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL sat_claim%0d got %b want 1", n, rd_ready); end
      step();
    end
    #1;
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL sat_fourth got %b want 0", rd_ready); end
    step();
    k = 0; acc = 0;
    while (!acc && k < 4) begin
      if (k == 0) wb(1'b1, 4'h3, 64'h33, 1'b0, 4'hF, '0);
      else        wb(1'b0, 4'hF, '0, 1'b0, 4'hF, '0);
      #1;
      acc = rd_ready;
      step();
      if (!acc) k++;
    end
    idle();
    checks++; if (k !== (BYP ? 0 : 1)) begin errors++; $display("FAIL sat_release got %0d want %0d", k, BYP ? 0 : 1); end
    checks++; if (pend !== exp_pend()) begin errors++; $display("FAIL sat_pend got %h want %h", pend, exp_pend()); end
  endtask

  task automatic test_nrd4();
    drive(1'b1, 16'hFFFF, 4'h6, 4'h7);
    step();
    drive(1'b1, 16'hFFFF, 4'h8, 4'h9);
    wb(1'b1, 4'h6, 64'h6060_0000_0000_0006, 1'b1, 4'h7, 64'h7070_0000_0000_0007);
    step();
    drive(1'b0, 16'hFFFF, 4'hF, 4'hF);
    wb(1'b1, 4'h8, 64'h8080_0000_0000_0008, 1'b1, 4'h9, 64'h9090_0000_0000_0009);
    step();
    wb(1'b0, 4'hF, '0, 1'b0, 4'hF, '0);
    drive(1'b1, 16'h9876, 4'hF, 4'hF);
    #1;
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL nrd4_ready got %b want 1", rd_ready); end
    step();
    idle();
    checks++; if (rd_data !== {64'h9090_0000_0000_0009, 64'h8080_0000_0000_0008,
                                64'h7070_0000_0000_0007, 64'h6060_0000_0000_0006}) begin
      errors++; $display("FAIL nrd4_data got %h", rd_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int q[$];
      logic [15:0] a;
      bit ee, me;
      logic [3:0] ed, md;
      for (int i = 0; i < NRD; i++)
        a[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      drive($urandom_range(0, 3) != 0, a,
            $urandom_range(0, 1) ? 4'($urandom_range(0, 14)) : 4'hF,
            $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 14)) : 4'hF);
      for (int r = 0; r < 15; r++) if (m_cnt[r] > 0) q.push_back(r);
      ee = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      me = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      ed = ee ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'hF;
      md = me ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'hF;
      if (ee && me && ed == md && m_cnt[ed] < 2) begin me = 0; md = 4'hF; end
      wb(ee, ed, {$urandom, $urandom}, me, md, {$urandom, $urandom});
      #1;
      checks++; if (rd_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, rd_ready, exp_ready()); end
      step();
      checks++; if (rd_data_valid !== m_rdv) begin errors++; $display("FAIL rnd_rdv n=%0d got %b want %b", n, rd_data_valid, m_rdv); end
      checks++; if (rd_data !== m_rdd) begin errors++; $display("FAIL rnd_data n=%0d got %h want %h", n, rd_data, m_rdd); end
      checks++; if (pend !== exp_pend()) begin errors++; $display("FAIL rnd_pend n=%0d got %h want %h", n, pend, exp_pend()); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b want %b", n, err, m_err); end
    end
    idle();
  endtask

  task automatic test_err_and_async_reset();
    rst_n = 1'b0;
    m_reset();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    wb(1'b1, 4'h5, 64'h55, 1'b0, 4'hF, '0);
    step();
    idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    checks++; if (pend[5] !== 1'b0) begin errors++; $display("FAIL err_clamp got %b want 0", pend[5]); end
    step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    drive(1'b1, 16'hFFF5, 4'h7, 4'hF);
    step();
    idle();
    checks++; if (rd_data[63:0] !== 64'h55) begin errors++; $display("FAIL err_written got %h want 55", rd_data[63:0]); end
    checks++; if (pend[7] !== 1'b1) begin errors++; $display("FAIL err_claim7 got %b want 1", pend[7]); end
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (pend !== 15'h0) begin errors++; $display("FAIL async_pend got %h want 0", pend); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err got %b want 0", err); end
    checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL async_rdv got %b want 0", rd_data_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_reset();
    #12;
    test_reset();
    test_basic_read();
    test_hazard();
    test_popq();
    test_saturate();
    test_nrd4();
    test_random();
    test_err_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/y86_regfile_sb.md
# y86_regfile_sb

Parametrised Y86-64 register file with scoreboarded hazard tracking for the pipelined processor. Sits in the decode stage: it accepts source-register reads, registers the operand values, and records destination claims for in-flight instructions. It retires those claims on E/M writeback and stalls decode while any source is still pending. It replaces the single-cycle combinational SEQ decode read path.

## Interface
- `DATA_W`, 64, register and operand width
- `NRD`, 2, number of read ports (1..4)
- `CNT_W`, 2, width of each per-register pending counter; maximum outstanding claims per register = 2^CNT_W-1

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rd_valid`  in  1  decode presents a read/claim request
- `rd_addr`  in  NRD*4  source register IDs; port i at [4i+3:4i]; 4'hF = RNONE
- `rd_ready`  out  1  request accepted this cycle (combinational)
- `rd_data`  out  NRD*DATA_W  registered operands; port i at [DATA_W*i +: DATA_W]
- `rd_data_valid`  out  1  one-cycle pulse, cycle after acceptance
- `claim_e`, `claim_m`  in  4 each  destination IDs claimed by the accepted instruction; F = none
- `wb_e_en`, `wb_m_en`  in  1 each  writeback strobes
- `wb_e_dst`, `wb_m_dst`  in  4 each  writeback register IDs
- `wb_e_data`, `wb_m_data`  in  DATA_W each  writeback values
- `pend`  out  15  bit r = counter[r] != 0
- `err`  out  1  sticky protocol error

## Operation
- Storage: 15 registers of DATA_W bits (IDs 0..14), plus 15 counters of CNT_W bits.
- Writeback:
  - Each enabled port with dst != F writes its data.
  - If `wb_e_dst == wb_m_dst`, M data wins (popq %rsp semantics).
  - Each enabled port with dst != F decrements that register's counter by 1; two ports on the same register decrement by 2.
- Read/claim acceptance: `rd_ready` = 1 when both conditions hold:
  - every port i with `rd_addr[i]` != F has effective count 0;
  - for each register, effective count + claims (`claim_e`, `claim_m` each count 1, equal IDs count 2) ≤ 2^CNT_W-1.
  - Effective count is the counter minus same-cycle writebacks to that register when `REGFILE_BYPASS_EN` is defined, and the raw counter otherwise.
- On `rd_valid && rd_ready`:
  - `rd_data[i]` loads the register value; RNONE reads 0.
  - Claims increment their counters.
  - `rd_data_valid` is 1 the next cycle.
- With `rd_valid` low, claims are ignored; `rd_data` holds and `rd_data_valid` = 0.
- Net counter update per cycle = accepted claims − writebacks.
- Error cases (data write still performed):
  - Writeback to a register whose counter would go below 0: `err` is set, the counter clamps at 0.
  - `err` is cleared only by reset.

## Timing
- Reset values: all registers 0, all counters 0, `rd_data` 0, `rd_data_valid` 0, `err` 0, `pend` 0.
- Reset asserted mid-operation discards all pending claims immediately, asynchronously.
- Latency:
  - Read: accept at edge N, `rd_data`/`rd_data_valid` visible after edge N.
  - Write: register value is readable from edge N+1, or at edge N itself with bypass.
- `rd_ready` depends combinationally on `rd_addr`, the claims and the wb_* inputs. No combinational path exists from `rd_valid` to `rd_ready`.
- Stall: decode holds `rd_addr`/claims stable until `rd_ready`; repeated requests while stalled have no side effects.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A same-cycle writeback that brings a source's counter to 0 satisfies the read.
  - The captured `rd_data` takes the writeback value, M over E.
- Not defined:
  - The read stalls one extra cycle until the counter is 0, then reads the array.
  - The bypass muxes are removed.

## Test plan
- Reset, then read rA=1, rB=F with no claims -> `rd_ready`=1; next cycle `rd_data_valid`=1, port0=0, port1=0.
- Claim dstE=2; next request reads 2 -> `rd_ready`=0, `pend[2]`=1; `wb_e_dst`=2 with 0xAAAA:
  - bypass on: accepted that cycle, port0=0xAAAA;
  - bypass off: accepted next cycle, port0=0xAAAA.
- popq-style claim_e=claim_m=4, then wb E(4,0x11) and M(4,0x22) same cycle -> counter 2→0, register 4 = 0x22, `err`=0.
- Four claims of register 3 with CNT_W=2 -> the fourth stalls until one wb to 3 retires.
- wb to register 5 with counter 0 -> `err`=1 and stays 1, register 5 written; assert `rst_n`=0 mid-stream -> `pend`=0, `err`=0 without a clock edge.
- NRD=4, all four ports read distinct written registers -> all four values correct in one accepted cycle.
